// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined adder/subtractor:
//     DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//     MAX_CHUNK              : widest chunk one stage may handle
//     chunk_add()            : {cout, sum} of two chunks plus carry-in
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int MAX_CHUNK  = 64;

    // Operands are zero-extended to MAX_CHUNK by the caller. The carry out of
    // a CHUNK-bit add then lands in bit CHUNK of the result.
    function automatic logic [MAX_CHUNK:0] chunk_add(
        input logic [MAX_CHUNK-1:0] a,
        input logic [MAX_CHUNK-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_CHUNK{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_stage.sv
// ----------------------------------------------------------------------------
// adder_stage
//   One registered CHUNK-bit slice of the ripple-carry pipe. It adds chunk IDX
//   of the delayed operands plus the incoming carry. The result is written into
//   the partial-sum word above the lower bits produced by earlier stages. The
//   operands are forwarded so that later stages can consume their own chunks.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     en              : global advance; every register holds when low
//     a_i, b_i        : operands (b already inverted for subtract)
//     sum_i, c_i      : partial sum and carry from the previous stage
//     a_o, b_o        : registered operands
//     sum_o, c_o      : registered partial sum and carry out of this chunk
// ----------------------------------------------------------------------------
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_WIDTH / DEF_STAGES,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);

    localparam int LO = IDX * CHUNK;

    if (CHUNK > MAX_CHUNK) begin : g_chunk_chk
        $error("adder_stage: CHUNK (%0d) exceeds MAX_CHUNK (%0d)", CHUNK, MAX_CHUNK);
    end

    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             c_d, c_q;
    logic [MAX_CHUNK:0] res;

    always_comb begin
        res   = chunk_add(MAX_CHUNK'(a_i[LO +: CHUNK]), MAX_CHUNK'(b_i[LO +: CHUNK]), c_i);
        a_d   = a_i;
        b_d   = b_i;
        sum_d = sum_i;
        sum_d[LO +: CHUNK] = res[CHUNK-1:0];
        c_d   = res[CHUNK];
    end

    // Only the low CHUNK+1 bits of the widened add carry information.
    logic unused_res;
    assign unused_res = ^res;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
        end else if (en) begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            c_q   <= c_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign sum_o = sum_q;
    assign c_o   = c_q;

endmodule

// File: rtl/pipelined_adder.sv
// ----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder/subtractor split into STAGES ripple-carry chunks. There is
//   one chunk per register stage and one operation per clock. The whole pipe
//   advances or holds as a unit, controlled by valid/ready on each side.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_valid / in_ready   : operand handshake
//     in_a, in_b            : operands
//     in_cin                : carry-in (ignored when subtracting)
//     in_sub                : 1 = A-B, 0 = A+B+cin
//     out_valid / out_ready : result handshake
//     out_sum               : result mod 2^WIDTH
//     out_cout              : carry out of MSB (subtract: 1 = no borrow)
// ----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_width_chk
        $error("pipelined_adder: WIDTH (%0d) not divisible by STAGES (%0d)", WIDTH, STAGES);
    end

    logic adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtract as A + ~B + 1, so the stage datapath is always a plain add.
    always_comb begin
        b_eff = in_sub ? ~in_b : in_b;
        c0    = in_sub ? 1'b1 : in_cin;
    end

    // The pipe moves only when the output slot is empty or being drained.
    // Bubbles are not squeezed, so in_ready follows the output side directly.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Valid shift register. vld_pipe[0] is the incoming beat and
    // vld_pipe[k] is the valid bit of stage k-1.
    logic [STAGES-1:0] vld_pipe_d, vld_pipe_q;
    logic [STAGES:0]   vld_pipe;

    assign vld_pipe = {vld_pipe_q, in_valid};

    always_comb begin
        vld_pipe_d = vld_pipe[STAGES-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else if (adv) begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    logic [STAGES-1:0][WIDTH-1:0] stg_a, stg_b, stg_sum;
    logic [STAGES-1:0]            stg_c;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, sum_in;
        logic             c_in;

        if (k == 0) begin : g_head
            assign a_in   = in_a;
            assign b_in   = b_eff;
            assign sum_in = '0;
            assign c_in   = c0;
        end else begin : g_body
            assign a_in   = stg_a[k-1];
            assign b_in   = stg_b[k-1];
            assign sum_in = stg_sum[k-1];
            assign c_in   = stg_c[k-1];
        end

        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .a_i   (a_in),
            .b_i   (b_in),
            .sum_i (sum_in),
            .c_i   (c_in),
            .a_o   (stg_a[k]),
            .b_o   (stg_b[k]),
            .sum_o (stg_sum[k]),
            .c_o   (stg_c[k])
        );
    end

    // The last stage has no consumer for its forwarded operands.
    logic unused_tail;
    assign unused_tail = ^{stg_a[STAGES-1], stg_b[STAGES-1]};

    assign out_valid = vld_pipe[STAGES];
    assign out_sum   = stg_sum[STAGES-1];
    assign out_cout  = stg_c[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_cin, in_sub, out_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_ready, out_valid, out_cout;
    logic [W-1:0] out_sum;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Cycle-level reference: S valid slots plus results, computed as a plain add.
    logic [S:1] m_v;
    logic [W:0] m_r [1:S];
    logic       m_adv;
    bit         acc;
    int         n_out = 0;

    function automatic logic [W:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W:0] bb;
        bb = sub ? {1'b0, ~b} : {1'b0, b};
        return {1'b0, a} + bb + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    endfunction

    task automatic model_clear();
        m_v = '0;
        for (int k = 1; k <= S; k++) m_r[k] = '0;
    endtask

    // Inputs were set at the falling edge. Sample, then let one rising edge pass.
    task automatic step();
        #1;
        m_adv = !m_v[S] || out_ready;
        chk("out_valid", out_valid, m_v[S]);
        chk("in_ready", in_ready, m_adv);
        if (m_v[S]) chk("result", {out_cout, out_sum}, m_r[S]);
        if (m_v[S] && out_ready) n_out++;
        acc = in_valid && m_adv;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (m_adv) begin
            for (int k = S; k > 1; k--) begin
                m_v[k] = m_v[k-1];
                m_r[k] = m_r[k-1];
            end
            m_v[1] = in_valid;
            m_r[1] = ref_res(in_a, in_b, in_cin, in_sub);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
    endtask

    // One beat, then check the hand-computed result exactly S cycles later.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] exp_sum, input logic exp_cout);
        drive(a, b, cin, sub);
        step();
        in_valid = 1'b0;
        repeat (S - 1) step();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_sum"}, out_sum, exp_sum);
        chk({tag, "_cout"}, out_cout, exp_cout);
        step();
    endtask

    logic [W-1:0] va [$];
    logic [W-1:0] vb [$];
    logic         vc [$];
    logic         vs [$];

    initial begin
        int n0, idx, cyc;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, '0);
        chk("rst_out_cout", out_cout, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (3) step();

        // Carry across every chunk boundary, subtract with and without borrow
        directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0 | 1'b1, 32'hFFFF_FFFE, 1'b0);
        directed("sub_ok", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        directed("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
        directed("add_cin", 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0);
        directed("msb_wrap", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        directed("sub_cin_ign", 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000F, 1'b1);

        // Random stream at full throughput
        for (int i = 0; i < 100; i++) begin
            va.push_back($urandom); vb.push_back($urandom);
            vc.push_back(1'($urandom_range(1))); vs.push_back(1'($urandom_range(1)));
        end
        n0 = n_out; idx = 0; cyc = 0;
        while (idx < 100 && cyc < 1000) begin
            drive(va[idx], vb[idx], vc[idx], vs[idx]);
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (S + 2) step();
        chk("stream_count", n_out - n0, 100);
        chk("stream_cycles", cyc, 100);

        // Backpressure with a full pipe
        n0 = n_out; idx = 0; cyc = 0;
        while (idx < 12 && cyc < 200) begin
            out_ready = !(cyc >= 5 && cyc < 11);
            drive(va[idx] ^ 32'hA5A5_0000, vb[idx], vc[idx], vs[idx]);
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (S + 2) step();
        chk("stall_count", n_out - n0, 12);

        // Reset with three beats in flight
        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_1000 + 32'(i), 32'h0000_0100, 1'b0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("flush_vld", out_valid, 1'b0);
        rst = 1'b0;
        directed("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
        repeat (S) step();
        chk("flush_count", n_out - n0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
